gb_audio_out: RTL and testbench
===============================

GB_AUDIO_OUT -- requirements
Module: gb_audio_out

Interface
REQ-001 SHALL have parameter DECIM_LOG2, default 5, meaning the decimation factor is 2^DECIM_LOG2 ce pulses per output sample (legal range 1..8).
REQ-002 SHALL have parameter BCLK_DIV, default 8, meaning clk cycles per bclk half-period (legal range 2..255).
REQ-003 clk  input  1  system clock; reset  input  1  reset, synchronous, active-high.
REQ-004 ce  input  1  sound-core clock enable, the same strobe that drives the sound core.
REQ-005 snd_left  input  16  left sample, signed two's complement, valid every clk.
REQ-006 snd_right  input  16  right sample, signed two's complement, valid every clk.
REQ-007 mute  input  1  when high, the serializer transmits zero data.
REQ-008 clear_flags  input  1  clears both sticky flags.
REQ-009 i2s_bclk, i2s_lrclk, i2s_data  output  1 each  I2S bit clock, word select (0 = left) and serial data.
REQ-010 underflow, overflow  output  1 each  sticky FIFO error flags.

Function
REQ-011 Decimator: each channel SHALL hold a signed accumulator of (16+DECIM_LOG2) bits and a DECIM_LOG2-bit ce counter.
REQ-012 On each ce, the sign-extended sample SHALL be added to the accumulator and the counter incremented.
REQ-013 On the ce where the counter equals all-ones, the new sum (current sample included) SHALL be arithmetic-shifted right by DECIM_LOG2 (floor toward -inf).
REQ-014 That shifted result SHALL be pushed into the FIFO on the next clk edge; the accumulator restarts at 0 and the counter wraps to 0.
REQ-015 FIFO: 4 entries of {left[15:0], right[15:0]} SHALL be provided, with full and empty derived from a 3-bit occupancy count.
REQ-016 A push while full, with no pop in the same cycle, SHALL be dropped (FIFO contents unchanged) and SHALL set overflow.
REQ-017 A simultaneous push and pop while full SHALL both succeed with no overflow.
REQ-018 Bit clock: a counter SHALL toggle i2s_bclk every BCLK_DIV clk cycles.
REQ-019 A 5-bit bit_cnt (0..31) SHALL advance, wrapping 31->0, on every bclk falling edge (1->0 toggle).
REQ-020 i2s_lrclk SHALL be 0 for bit_cnt in {31, 0..14} and 1 for bit_cnt in 15..30, so it leads the MSB by one bclk.
REQ-021 i2s_data SHALL be out_l[15-n] for bit_cnt n in 0..15, out_r[31-n] for n in 16..31, and 0 while mute is high.
REQ-022 i2s_lrclk and i2s_data SHALL change only on the clk edge that makes bclk fall.
REQ-023 Frame load: on the bit_cnt 31->0 transition, if the FIFO is not empty, {out_l, out_r} SHALL load from the FIFO head and pop it.
REQ-024 On the bit_cnt 31->0 transition with an empty FIFO, {out_l, out_r} SHALL hold the previous values (repeat) and underflow SHALL be set.
REQ-025 mute SHALL NOT stop FIFO pops or decimation.
REQ-026 clear_flags high SHALL clear both flags on that edge; a flag-setting event in the same cycle SHALL take priority (flag ends at 1).

Reset
REQ-027 reset SHALL clear the accumulators, ce counters, FIFO pointers and count, out_l, out_r, the bclk divider and bit_cnt to 0.
REQ-028 During reset, i2s_bclk=0, i2s_lrclk=0, i2s_data=0, underflow=0 and overflow=0.
REQ-029 The first bclk rising edge SHALL occur BCLK_DIV clk cycles after reset deasserts.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no partial word completed afterward.
REQ-031 Reset SHALL override ce, clear_flags and all FIFO activity in the same cycle.

Verification
REQ-032 DECIM_LOG2=2, ce every cycle, snd_left=0x1000 constant, snd_right=0xF000 constant -> FIFO entry {0x1000, 0xF000} pushed one clk after the 4th ce.
REQ-033 DECIM_LOG2=1, left samples 3 then -4 -> pushed left = 0xFFFF (floor of -1/2).
REQ-034 BCLK_DIV=2, FIFO holds {0xA5C3, 0x0F0F} -> frame shows lrclk low at bit 31, left MSB first 1010010111000011, lrclk high from bit 15, then right 0000111100001111.
REQ-035 FIFO empty at frame load, last sample {0x1234, 0x5678} -> same bits retransmitted and underflow=1; clear_flags pulse -> underflow=0.
REQ-036 Six pushes with no pops -> 4 entries retained, first four values popped in order, overflow=1.
REQ-037 Reset asserted at bit_cnt=20 -> all outputs 0 next edge, first bclk rise exactly BCLK_DIV clk after release, mute high -> i2s_data constant 0 while lrclk keeps toggling.

Source files
------------

// File: rtl/gb_audio_out.sv
// Sound-core to I2S bridge: box-filter decimation of the ce-rate stereo stream,
// a 4-deep sample FIFO, and a free-running 32-bit-frame I2S serializer with sticky error flags.
module gb_audio_out #(
  parameter int DECIM_LOG2 = 5,
  parameter int BCLK_DIV   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] snd_left,
  input  logic [15:0] snd_right,
  input  logic        mute,
  input  logic        clear_flags,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_data,
  output logic        underflow,
  output logic        overflow
);
  localparam int ACC_W = 16 + DECIM_LOG2;

  // Decimator state
  logic signed [ACC_W-1:0]  acc_l, acc_r;
  logic signed [ACC_W-1:0]  sum_l, sum_r;
  logic        [15:0]       avg_l, avg_r;
  logic [DECIM_LOG2-1:0]    ce_cnt_l, ce_cnt_r;
  logic                     push_valid;
  logic [31:0]              push_data;

  // FIFO state
  logic [31:0] fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  fifo_count;
  logic        fifo_full, fifo_empty;
  logic        push, pop;
  logic        overflow_event, underflow_event;

  // Serializer state
  logic [7:0]  div_cnt;
  logic        div_tick, bclk_fall, frame_load;
  logic [4:0]  bit_cnt, next_bit, bit_idx;
  logic [15:0] out_l, out_r;
  logic [31:0] next_frame;

  // Sum includes the current sample so the wrap cycle sees the complete window.
  always_comb begin
    sum_l = acc_l + {{DECIM_LOG2{snd_left[15]}}, snd_left};
    sum_r = acc_r + {{DECIM_LOG2{snd_right[15]}}, snd_right};
    avg_l = 16'(sum_l >>> DECIM_LOG2);
    avg_r = 16'(sum_r >>> DECIM_LOG2);
  end

  always_comb begin
    fifo_full       = (fifo_count == 3'd4);
    fifo_empty      = (fifo_count == 3'd0);
    div_tick        = (div_cnt == 8'(BCLK_DIV - 1));
    bclk_fall       = div_tick & i2s_bclk;
    frame_load      = bclk_fall & (bit_cnt == 5'd31);
    pop             = frame_load & ~fifo_empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    push            = push_valid & (~fifo_full | pop);
    overflow_event  = push_valid & fifo_full & ~pop;
    underflow_event = frame_load & fifo_empty;
    next_bit        = bit_cnt + 5'd1;
    next_frame      = pop ? fifo_mem[rd_ptr] : {out_l, out_r};
    bit_idx         = 5'd31 - next_bit;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_l      <= '0;
      acc_r      <= '0;
      ce_cnt_l   <= '0;
      ce_cnt_r   <= '0;
      push_valid <= 1'b0;
      push_data  <= '0;
    end else begin
      push_valid <= 1'b0;
      if (ce) begin
        if (&ce_cnt_l) begin
          acc_l            <= '0;
          ce_cnt_l         <= '0;
          push_valid       <= 1'b1;
          push_data[31:16] <= avg_l;
        end else begin
          acc_l    <= sum_l;
          ce_cnt_l <= ce_cnt_l + DECIM_LOG2'(1);
        end
        if (&ce_cnt_r) begin
          acc_r           <= '0;
          ce_cnt_r        <= '0;
          push_data[15:0] <= avg_r;
        end else begin
          acc_r    <= sum_r;
          ce_cnt_r <= ce_cnt_r + DECIM_LOG2'(1);
        end
      end
    end
  end

  // NOTE: the sample storage has no reset; occupancy and pointers alone decide
  // what is readable, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push && !reset) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Word select and data only move on the edge that drops bclk, so both are
  // stable across the following rising edge where the receiver samples them.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      i2s_bclk  <= 1'b0;
      bit_cnt   <= '0;
      i2s_lrclk <= 1'b0;
      i2s_data  <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
    end else begin
      if (div_tick) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (bclk_fall) begin
        bit_cnt   <= next_bit;
        i2s_lrclk <= (next_bit >= 5'd15) && (next_bit <= 5'd30);
        i2s_data  <= ~mute & next_frame[bit_idx];
        if (frame_load) {out_l, out_r} <= next_frame;
      end
    end
  end

  // A setting event wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (underflow_event)  underflow <= 1'b1;
      else if (clear_flags) underflow <= 1'b0;
      if (overflow_event)   overflow  <= 1'b1;
      else if (clear_flags) overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gb_audio_out.sv
// Randomized scoreboard bench for gb_audio_out: a clk-edge reference model predicts
// each I2S frame and the sticky flags; a monitor deserializes frames and compares.
module tb_gb_audio_out;
  localparam int DECIM_LOG2 = 2;
  localparam int BCLK_DIV   = 2;
  localparam int N_AVG      = 1 << DECIM_LOG2;
  localparam int FALL_CLKS  = 2 * BCLK_DIV;
  localparam int FRAME_CLKS = 32 * FALL_CLKS;
  localparam logic [31:0] LR_PATTERN = 32'h0001_FFFE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic [15:0] snd_left = '0;
  logic [15:0] snd_right = '0;
  logic        mute = 1'b0;
  logic        clear_flags = 1'b0;
  logic        i2s_bclk, i2s_lrclk, i2s_data, underflow, overflow;

  gb_audio_out #(.DECIM_LOG2(DECIM_LOG2), .BCLK_DIV(BCLK_DIV)) dut (
    .clk(clk), .reset(reset), .ce(ce), .snd_left(snd_left), .snd_right(snd_right),
    .mute(mute), .clear_flags(clear_flags), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_data(i2s_data), .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: everything is timed in clk edges since reset release.
  int          n;
  int          grp_k, sum_l, sum_r;
  bit          push_pend;
  logic [31:0] push_val;
  logic [31:0] mfifo[$];
  logic [31:0] cur_frame, exp_word;
  bit          exp_uf, exp_of, last_rst;
  logic [31:0] exp_q[$];
  int          step_cnt = 0;
  bit          mon_en = 1'b1;

  function automatic logic [15:0] floor_avg(input int s);
    int q = s / N_AVG;
    if ((s % N_AVG) != 0 && s < 0) q = q - 1;
    return q[15:0];
  endfunction

  function automatic int bit_pos();
    return (n / FALL_CLKS) % 32;
  endfunction

  task automatic model_edge(input bit r, input bit c, input logic [15:0] l,
                            input logic [15:0] rt, input bit mu, input bit clr);
    bit uf_ev, of_ev;
    int b;
    last_rst = r;
    if (r) begin
      n = 0; grp_k = 0; sum_l = 0; sum_r = 0; push_pend = 0; push_val = '0;
      mfifo.delete(); exp_q.delete();
      cur_frame = '0; exp_word = '0; exp_uf = 0; exp_of = 0;
      return;
    end
    n++;
    uf_ev = 0; of_ev = 0;
    if (n % FALL_CLKS == 0) begin
      b = bit_pos();
      if (b == 0) begin
        if (mfifo.size() > 0) cur_frame = mfifo.pop_front();
        else uf_ev = 1;
      end
      exp_word[31-b] = mu ? 1'b0 : cur_frame[31-b];
      if (b == 31) exp_q.push_back(exp_word);
    end
    if (push_pend) begin
      if (mfifo.size() < 4) mfifo.push_back(push_val);
      else of_ev = 1;
      push_pend = 0;
    end
    if (c) begin
      sum_l = sum_l + $signed(l);
      sum_r = sum_r + $signed(rt);
      grp_k++;
      if (grp_k == N_AVG) begin
        push_pend = 1;
        push_val  = {floor_avg(sum_l), floor_avg(sum_r)};
        grp_k = 0; sum_l = 0; sum_r = 0;
      end
    end
    if (uf_ev) exp_uf = 1; else if (clr) exp_uf = 0;
    if (of_ev) exp_of = 1; else if (clr) exp_of = 0;
  endtask

  // One clk cycle: check the state left by the previous edge, then apply new inputs.
  task automatic drive(input bit r, input bit c, input logic [15:0] l, input logic [15:0] rt,
                       input bit mu, input bit clr, input bit chk);
    @(negedge clk);
    if (chk || last_rst || (step_cnt % 16 == 0)) begin
      check("underflow", underflow, exp_uf);
      check("overflow", overflow, exp_of);
      check("bclk", i2s_bclk, last_rst ? 1'b0 : 1'((n / BCLK_DIV) % 2));
      if (last_rst) begin
        check("reset_lrclk", i2s_lrclk, 1'b0);
        check("reset_data", i2s_data, 1'b0);
      end
    end
    step_cnt++;
    reset = r; ce = c; snd_left = l; snd_right = rt; mute = mu; clear_flags = clr;
    model_edge(r, c, l, rt, mu, clr);
  endtask

  task automatic idle(input int cycles, input bit mu);
    for (int i = 0; i < cycles; i++) drive(0, 0, 16'h0, 16'h0, mu, 0, 0);
  endtask

  // Monitor: deserialize on bclk rising edges and compare whole frames.
  initial begin
    int idx = 0;
    logic [31:0] got_d = '0, got_lr = '0, exp_d;
    logic prev_bclk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        idx = 0; got_d = '0; got_lr = '0; prev_bclk = 1'b0;
        continue;
      end
      if (mon_en && i2s_bclk && !prev_bclk) begin
        got_d[31-idx]  = i2s_data;
        got_lr[31-idx] = i2s_lrclk;
        if (idx == 31) begin
          check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            exp_d = exp_q.pop_front();
            check("frame_data", got_d, exp_d);
            check("frame_lrclk", got_lr, LR_PATTERN);
          end
        end
        idx = (idx + 1) % 32;
      end
      prev_bclk = i2s_bclk;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, frames pending %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    last_rst = 1;
    model_edge(1, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 0, 16'h0, 16'h0, 0, 0, 1);

    // Known frame, then repeats from an empty FIFO, then a flag clear.
    repeat (N_AVG) drive(0, 1, 16'hA5C3, 16'h0F0F, 0, 0, 0);
    idle(3 * FRAME_CLKS, 0);
    drive(0, 0, 16'h0, 16'h0, 0, 1, 1);
    drive(0, 0, 16'h0, 16'h0, 0, 0, 1);

    // Floor rounding of a negative mean: (3-4-4-4)/4 -> -3.
    drive(0, 1, 16'h0003, 16'h1234, 0, 0, 0);
    repeat (N_AVG - 1) drive(0, 1, 16'hFFFC, 16'h1234, 0, 0, 0);
    idle(FRAME_CLKS, 0);

    // Six back-to-back pushes with no pop in between overflow the FIFO.
    while (bit_pos() != 2) drive(0, 0, 16'h0, 16'h0, 0, 0, 0);
    repeat (6 * N_AVG) drive(0, 1, 16'h1000, 16'hF000, 0, 0, 0);
    drive(0, 0, 16'h0, 16'h0, 0, 0, 1);
    idle(6 * FRAME_CLKS, 0);
    drive(0, 0, 16'h0, 16'h0, 0, 1, 1);

    // Random segments with varied sample rates, mute and clear pulses.
    for (int s = 0; s < 8; s++) begin
      int ce_div;
      bit mu;
      case ($urandom % 4)
        0:       ce_div = 2;
        1:       ce_div = 16;
        2:       ce_div = 32;
        default: ce_div = 64;
      endcase
      mu = (($urandom % 4) == 0);
      for (int i = 0; i < 3 * FRAME_CLKS; i++)
        drive(0, ($urandom % ce_div) == 0, 16'($urandom), 16'($urandom), mu,
              ($urandom % 200) == 0, 0);
    end

    // Reset in the middle of a frame, then muted operation.
    for (int i = 0; i < 2 * FRAME_CLKS && bit_pos() != 20; i++)
      drive(0, ($urandom % 8) == 0, 16'($urandom), 16'($urandom), 0, 0, 0);
    check("reached_bit20", 32'(bit_pos()), 32'd20);
    repeat (2) drive(1, 1, 16'($urandom), 16'($urandom), 0, 1, 1);
    for (int i = 0; i < 2 * FALL_CLKS + 4; i++)
      drive(0, ($urandom % 8) == 0, 16'($urandom), 16'($urandom), 1, 0, 1);
    for (int i = 0; i < 3 * FRAME_CLKS; i++)
      drive(0, ($urandom % 8) == 0, 16'($urandom), 16'($urandom), 1, 0, 0);

    // Drain: stop where no frame completion is imminent.
    for (int i = 0; i < 4 * FRAME_CLKS; i++) begin
      if (i >= FRAME_CLKS && exp_q.size() == 0 && bit_pos() >= 1 && bit_pos() <= 29) break;
      drive(0, 0, 16'h0, 16'h0, 0, 0, 0);
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
